// File: rtl/fm_pingpong_scheduler_if.sv
// Handshake/address bundle between the ping-pong feature-map scheduler and its
// producer/consumer side.
//   slave  : the scheduler. It takes wr_valid and rd_ready, and drives the rest.
//   master : the producer/consumer. It drives wr_valid and rd_ready, and observes the rest.
// Signals:
//   wr_valid/wr_ready/wr_en  producer handshake and RAM write strobe
//   wr_bank/wr_addr          write bank select and address
//   rd_ready/rd_en           consumer handshake and RAM read strobe
//   rd_bank/rd_addr          read bank select and address
//   rd_valid/rd_last         RAM data valid (1 cycle after rd_en), last word of a bank
//   bank_full                per-bank full flags
//   frame_done               1-cycle pulse after a bank finishes draining
interface fm_pingpong_scheduler_if #(
  parameter int ADDR_W = 7
);
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_ready;
  logic              rd_en;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_last;
  logic [1:0]        bank_full;
  logic              frame_done;

  modport slave (
    input  wr_valid, rd_ready,
    output wr_ready, wr_en, wr_bank, wr_addr,
    output rd_en, rd_bank, rd_addr, rd_valid, rd_last,
    output bank_full, frame_done
  );

  modport master (
    output wr_valid, rd_ready,
    input  wr_ready, wr_en, wr_bank, wr_addr,
    input  rd_en, rd_bank, rd_addr, rd_valid, rd_last,
    input  bank_full, frame_done
  );
endinterface

// File: rtl/fm_pingpong_scheduler.sv
// Ping-pong feature-map buffer sequencer. One producer fills one bank while one
// consumer drains the other bank. The module generates the RAM write and read
// strobes, addresses and bank selects, and tracks a full flag for each bank.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset
//   flush   synchronous abort with the same effect as reset; used for a layer restart
//   fm_bus  scheduler side (slave) of fm_pingpong_scheduler_if
// Writes issue with 0 latency. Read data is valid 1 cycle after rd_en.
module fm_pingpong_scheduler #(
  parameter int FM_DEPTH = 121,
  parameter int ADDR_W   = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  fm_pingpong_scheduler_if.slave    fm_bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_DEPTH - 1);

  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [1:0]        r_bank_full;
  logic              r_vld_p1;
  logic              r_rd_last_p1;
  logic              r_frame_done_p1;

  logic w_wr_ready;
  logic w_wr_en;
  logic w_wr_wrap;
  logic w_rd_en;
  logic w_rd_wrap;

  assign w_wr_ready = ~r_bank_full[r_wr_sel];
  assign w_wr_en    = fm_bus.wr_valid & w_wr_ready;
  assign w_wr_wrap  = w_wr_en & (r_wr_cnt == LAST_ADDR);
  assign w_rd_en    = r_bank_full[r_rd_sel] & fm_bus.rd_ready;
  assign w_rd_wrap  = w_rd_en & (r_rd_cnt == LAST_ADDR);

  // Stage p0: the strobes and addresses come straight from the current state.
  assign fm_bus.wr_ready   = w_wr_ready;
  assign fm_bus.wr_en      = w_wr_en;
  assign fm_bus.wr_bank    = r_wr_sel;
  assign fm_bus.wr_addr    = r_wr_cnt;
  assign fm_bus.rd_en      = w_rd_en;
  assign fm_bus.rd_bank    = r_rd_sel;
  assign fm_bus.rd_addr    = r_rd_cnt;
  assign fm_bus.bank_full  = r_bank_full;

  // Stage p1: these outputs follow the RAM read latency.
  assign fm_bus.rd_valid   = r_vld_p1;
  assign fm_bus.rd_last    = r_rd_last_p1;
  assign fm_bus.frame_done = r_frame_done_p1;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_sel        <= 1'b0;
      r_rd_sel        <= 1'b0;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_bank_full     <= 2'b00;
      r_vld_p1        <= 1'b0;
      r_rd_last_p1    <= 1'b0;
      r_frame_done_p1 <= 1'b0;
    end else begin
      // A write only targets a non-full bank, and a read only targets a full bank.
      // The set below and the clear further down therefore always hit different
      // bits, and both apply in the same cycle.
      if (w_wr_en) begin
        if (w_wr_wrap) begin
          r_wr_cnt              <= '0;
          r_bank_full[r_wr_sel] <= 1'b1;
          r_wr_sel              <= ~r_wr_sel;
        end else begin
          r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        end
      end
      if (w_rd_en) begin
        if (w_rd_wrap) begin
          r_rd_cnt              <= '0;
          r_bank_full[r_rd_sel] <= 1'b0;
          r_rd_sel              <= ~r_rd_sel;
        end else begin
          r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
        end
      end
      r_vld_p1        <= w_rd_en;
      r_rd_last_p1    <= w_rd_wrap;
      r_frame_done_p1 <= w_rd_wrap;
    end
  end

endmodule
